alu_control_unit: RTL and testbench

//  Multi-cycle control unit that drives the 8-bit combinational ALU from the other side of its interface.
//  - Accepts 16-bit instructions over a valid/ready handshake.
//  - Holds a 4x8 register file and reads operands from it.
//  - Drives the ALU operand and select lines, then captures the ALU result and zero flag.
//  - Writes the result back to the register file.
//  - Sits between the instruction source and the ALU in the RISC CPU datapath.

---
 rtl/alu_control_unit_if.sv | 28 ++
 rtl/alu_control_unit.sv | 93 +++++++++
 tb/tb_alu_control_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_unit_if.sv
// alu_control_unit_if: instruction handshake, ALU drive/return and status lines of the ALU control unit
interface alu_control_unit_if #(
    parameter int DW = 8,
    parameter int IW = 16
);
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_sel;
    logic [DW-1:0] alu_oper;
    logic          alu_zero;
    logic          zflag;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          done;

    modport master (
        output instr, instr_valid, alu_oper, alu_zero,
        input  instr_ready, alu_a, alu_b, alu_sel, zflag, data_out, data_valid, done
    );

    modport slave (
        input  instr, instr_valid, alu_oper, alu_zero,
        output instr_ready, alu_a, alu_b, alu_sel, zflag, data_out, data_valid, done
    );
endinterface

// File: rtl/alu_control_unit.sv
// alu_control_unit: multi-cycle control unit driving an 8-bit ALU; optional debug read port under ALU_CU_DBG_EN
module alu_control_unit #(
    parameter int DW   = 8,
    parameter int NREG = 4,
    parameter int IW   = 16
) (
    input  logic               clk,
    input  logic               rst,
    alu_control_unit_if.slave  bus
`ifdef ALU_CU_DBG_EN
    ,
    input  logic [1:0]         dbg_idx,
    output logic [DW-1:0]      dbg_data
`endif
);
    typedef enum logic [1:0] {IDLE, DEC, EXE, WB} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] ir;
    logic [DW-1:0] rf [NREG];
    logic [DW-1:0] result;
    logic          zflag_nx;

    wire       is_alu = ~ir[15];
    wire       is_ldi = ir[15:14] == 2'b10;
    wire       is_out = ir[15:14] == 2'b11;
    wire [1:0] rd     = ir[11:10];
    wire [1:0] rs     = ir[9:8];
    wire [1:0] rt     = ir[7:6];

    assign bus.instr_ready = state == IDLE;
    assign bus.done        = state == WB;

`ifdef ALU_CU_DBG_EN
    assign dbg_data = rf[dbg_idx];
`endif

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state: ALU ops pass through EXE, LDI/OUT skip straight to WB
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.instr_valid ? DEC : IDLE;
            DEC:     state_nx = is_alu ? EXE : WB;
            EXE:     state_nx = WB;
            default: state_nx = IDLE;
        endcase
    end

    // datapath: latch instruction, drive ALU, capture result, write back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir             <= '0;
            result         <= '0;
            zflag_nx       <= 1'b0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_sel    <= '0;
            bus.zflag      <= 1'b0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            bus.data_valid <= 1'b0;
            if (state == IDLE && bus.instr_valid) ir <= bus.instr;
            if (state == DEC && is_alu) begin
                bus.alu_a   <= rf[rs];
                bus.alu_b   <= rf[rt];
                bus.alu_sel <= ir[14:12];
            end
            if (state == EXE) begin
                result   <= bus.alu_oper;
                zflag_nx <= bus.alu_zero;
            end
            if (state == WB) begin
                if (is_alu) begin
                    rf[rd]    <= result;
                    bus.zflag <= zflag_nx;
                end
                if (is_ldi) rf[rd] <= ir[7:0];
                if (is_out) begin
                    bus.data_out   <= rf[rs];
                    bus.data_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_control_unit.sv
// tb_alu_control_unit: directed self-checking bench for alu_control_unit with a behavioural ALU
module tb_alu_control_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exe_a, exe_b;
    logic [2:0] exe_sel;

    alu_control_unit_if #(.DW(8), .IW(16)) bus ();

`ifdef ALU_CU_DBG_EN
    logic [1:0] dbg_idx = 2'd0;
    logic [7:0] dbg_data;
    alu_control_unit dut (.clk(clk), .rst(rst), .bus(bus), .dbg_idx(dbg_idx), .dbg_data(dbg_data));
`else
    alu_control_unit dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    // behavioural ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not a, 6 shl a, 7 shr a
    always_comb begin
        case (bus.alu_sel)
            3'd0:    bus.alu_oper = bus.alu_a + bus.alu_b;
            3'd1:    bus.alu_oper = bus.alu_a - bus.alu_b;
            3'd2:    bus.alu_oper = bus.alu_a & bus.alu_b;
            3'd3:    bus.alu_oper = bus.alu_a | bus.alu_b;
            3'd4:    bus.alu_oper = bus.alu_a ^ bus.alu_b;
            3'd5:    bus.alu_oper = ~bus.alu_a;
            3'd6:    bus.alu_oper = bus.alu_a << 1;
            default: bus.alu_oper = bus.alu_a >> 1;
        endcase
        bus.alu_zero = bus.alu_oper == 8'h00;
    end

    function automatic logic [15:0] alu_op(input int sel, input int rd, input int rs, input int rt);
        return 16'((sel << 12) | (rd << 10) | (rs << 8) | (rt << 6));
    endfunction

    function automatic logic [15:0] ldi(input int rd, input logic [7:0] imm);
        return 16'(16'h8000 | (rd << 10) | imm);
    endfunction

    function automatic logic [15:0] out(input int rs);
        return 16'(16'hC000 | (rs << 8));
    endfunction

    // issue one instruction; lat = edges from accept to Done (-1 on timeout); returns one cycle into IDLE
    task automatic issue(input logic [15:0] ins, output int lat);
        lat = -1;
        @(negedge clk);
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        for (int n = 0; n < 20 && !bus.instr_ready; n++) @(negedge clk);
        if (!bus.instr_ready) begin
            bus.instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                exe_a = bus.alu_a;
                exe_b = bus.alu_b;
                exe_sel = bus.alu_sel;
            end
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int lat;
        issue(ldi(0, 8'h12), lat);
        issue(ldi(1, 8'h34), lat);
        issue(ldi(2, 8'h56), lat);
        issue(ldi(3, 8'h78), lat);
        issue(alu_op(1, 0, 0, 0), lat);
        issue(out(1), lat);
        checks++;
        if (bus.data_out !== 8'h34) begin errors++; $display("FAIL pre_reset_out got %h want 34", bus.data_out); end
        @(negedge clk);
        bus.instr = ldi(2, 8'h77);
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.instr_ready, bus.zflag, bus.done, bus.data_valid, bus.data_out} !== {4'b1000, 8'h00})
            begin errors++; $display("FAIL reset_state got %b_%h want 1000_00", {bus.instr_ready, bus.zflag, bus.done, bus.data_valid}, bus.data_out); end
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            issue(out(r), lat);
            checks++;
            if (bus.data_out !== 8'h00 || bus.data_valid !== 1'b1 || lat !== 1)
                begin errors++; $display("FAIL reset_reg r%0d got %h/%b/%0d want 00/1/1", r, bus.data_out, bus.data_valid, lat); end
        end
    endtask

    task automatic test_add();
        int lat;
        issue(ldi(1, 8'h05), lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL ldi_latency got %0d want 1", lat); end
        issue(ldi(2, 8'h03), lat);
        issue(alu_op(0, 3, 1, 2), lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL alu_latency got %0d want 2", lat); end
        issue(out(3), lat);
        checks++;
        if (bus.data_out !== 8'h08 || bus.zflag !== 1'b0 || bus.data_valid !== 1'b1)
            begin errors++; $display("FAIL add_result got %h z%b v%b want 08 z0 v1", bus.data_out, bus.zflag, bus.data_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL data_valid_pulse got %b want 0", bus.data_valid); end
    endtask

    task automatic test_wrap();
        int lat;
        issue(ldi(0, 8'hFF), lat);
        issue(ldi(1, 8'h01), lat);
        issue(alu_op(0, 2, 0, 1), lat);
        issue(out(2), lat);
        checks++;
        if (bus.data_out !== 8'h00 || bus.zflag !== 1'b1)
            begin errors++; $display("FAIL wrap_add got %h z%b want 00 z1", bus.data_out, bus.zflag); end
        issue(ldi(3, 8'h44), lat);
        checks++;
        if (bus.zflag !== 1'b1) begin errors++; $display("FAIL ldi_keeps_z got %b want 1", bus.zflag); end
    endtask

    task automatic test_sub_hazard();
        int lat;
        issue(ldi(1, 8'h5A), lat);
        issue(alu_op(1, 1, 1, 1), lat);
        checks++;
        if (exe_a !== 8'h5A || exe_b !== 8'h5A || exe_sel !== 3'b001)
            begin errors++; $display("FAIL sub_exe_operands got %h %h %b want 5a 5a 001", exe_a, exe_b, exe_sel); end
        issue(out(1), lat);
        checks++;
        if (bus.data_out !== 8'h00 || bus.zflag !== 1'b1)
            begin errors++; $display("FAIL sub_self got %h z%b want 00 z1", bus.data_out, bus.zflag); end
    endtask

    task automatic test_xor();
        int lat;
        issue(ldi(0, 8'h0F), lat);
        issue(ldi(1, 8'hF0), lat);
        issue(alu_op(4, 3, 0, 1), lat);
        checks++;
        if (exe_sel !== 3'd4) begin errors++; $display("FAIL xor_sel got %b want 100", exe_sel); end
        issue(out(3), lat);
        checks++;
        if (bus.data_out !== 8'hFF || bus.zflag !== 1'b0)
            begin errors++; $display("FAIL xor_result got %h z%b want ff z0", bus.data_out, bus.zflag); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq [3];
        int acc = 0, cyc = 0, t0 = 0, t2 = 0, bad = 0, lat;
        seq[0] = ldi(0, 8'h11);
        seq[1] = ldi(1, 8'h22);
        seq[2] = alu_op(0, 2, 0, 1);
        @(negedge clk);
        bus.instr = seq[0];
        bus.instr_valid = 1'b1;
        while (acc < 3 && cyc < 40) begin
            if (bus.done && bus.instr_ready) bad++;
            if (bus.instr_ready) begin
                if (acc == 0) t0 = cyc;
                t2 = cyc;
                acc++;
                @(posedge clk);
                #1 if (acc < 3) bus.instr = seq[acc];
            end
            @(negedge clk);
            cyc++;
        end
        repeat (2) begin
            if (bus.done && bus.instr_ready) bad++;
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (acc !== 3 || t2 - t0 !== 6)
            begin errors++; $display("FAIL b2b_accepts got %0d span %0d want 3 span 6", acc, t2 - t0); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL b2b_ready_in_wb got %0d want 0", bad); end
        issue(out(0), lat);
        checks++;
        if (bus.data_out !== 8'h11) begin errors++; $display("FAIL b2b_r0 got %h want 11", bus.data_out); end
        issue(out(1), lat);
        checks++;
        if (bus.data_out !== 8'h22) begin errors++; $display("FAIL b2b_r1 got %h want 22", bus.data_out); end
        issue(out(2), lat);
        checks++;
        if (bus.data_out !== 8'h33) begin errors++; $display("FAIL b2b_r2 got %h want 33", bus.data_out); end
    endtask

`ifdef ALU_CU_DBG_EN
    task automatic test_dbg();
        int lat;
        dbg_idx = 2'd2;
        issue(ldi(2, 8'hA5), lat);
        checks++;
        if (dbg_data !== 8'hA5) begin errors++; $display("FAIL dbg_read got %h want a5", dbg_data); end
    endtask
`endif

    initial begin
        bus.instr = '0;
        bus.instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_add();
        test_wrap();
        test_sub_hazard();
        test_xor();
        test_back_to_back();
`ifdef ALU_CU_DBG_EN
        test_dbg();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
